dual_port_ram_param: RTL and testbench
======================================

Name: dual_port_ram_param

Overview:
- Parametrised simple dual-port RAM: one write port, one read port, single clock.
- Successor to the fixed 8x16 RAM, adding:
  - generic width and depth
  - byte-lane write enables
  - selectable read latency with a read-valid strobe
  - defined same-address collision behaviour
  - hardware init sweep in place of a per-word reset
- Serves as the general storage primitive for buffers and register files across the design.

Parameters:
- DATA_W, 16, data width in bits; must be a multiple of 8.
- ADDR_W, 3, address width; DEPTH = 2**ADDR_W words (derived, not overridable).
- RD_LATENCY, 1, read latency in cycles; legal values 1 or 2.
- COLLISION_MODE, 0, same-cycle same-address read/write: 0 = read-old, 1 = write-first.
- INIT_VAL, 0, DATA_W-bit value written to every word by the init sweep.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous request to re-run the init sweep.
- we  input  1  write enable.
- wbe  input  DATA_W/8  byte-lane enables; lane i covers wdata[8i+7:8i].
- waddr  input  ADDR_W  write address.
- wdata  input  DATA_W  write data.
- re  input  1  read enable.
- raddr  input  ADDR_W  read address.
- rdata  output  DATA_W  read data; valid only while rvalid=1.
- rvalid  output  1  one-cycle strobe per accepted read.
- busy  output  1  init sweep in progress; we/re ignored while high.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - rdata=0, rvalid=0, busy=1, FSM=INIT, sweep counter=0, read pipeline cleared.
  - Memory array is not reset directly.
- FSM states: INIT, READY.
- INIT:
  - Each clock writes INIT_VAL to mem[counter], then counter++.
  - After the write to address DEPTH-1: go to READY, busy=0 from the next cycle.
  - Sweep takes exactly DEPTH cycles after rst_n deasserts.
- READY -> INIT on clr=1 at a rising edge:
  - busy=1 from the next cycle, counter=0.
  - Any write presented in that same cycle is dropped.
- clr=1 while already in INIT restarts the counter at 0.
- While busy=1:
  - we and re are ignored.
  - rvalid is forced 0 and in-flight reads are flushed.
  - rdata holds its last value.
- Write (READY, we=1): for each lane with wbe[i]=1, mem[waddr] lane i <= wdata lane i. Other lanes unchanged. wbe=0 is a no-op.
- Read (READY, re=1 at edge N):
  - RD_LATENCY=1: rdata and rvalid=1 are presented after edge N, i.e. visible in cycle N+1.
  - RD_LATENCY=2: an extra output register, so visible in cycle N+2.
- Back-to-back reads: one accepted per cycle, full throughput; rvalid stays high continuously.
- rvalid=0 in any cycle with no matching accepted read; rdata holds between reads.
- Collision (we=1, re=1, waddr==raddr, same edge):
  - Mode 0: returns the pre-write word.
  - Mode 1: returns the merged word (enabled lanes from wdata, other lanes old).
- Writes and reads to different addresses in the same cycle are fully independent.
- Addresses wrap naturally at ADDR_W bits; there is no out-of-range case.
- Reset asserted mid-read or mid-sweep: outputs go to reset values immediately; the sweep restarts from 0 after release.

Optional Feature:
- Macro: DPRAM_PARITY_EN.
- With the macro defined:
  - Each word stores one even-parity bit per byte lane, computed at write and at init sweep. Unwritten lanes keep their old parity.
  - Extra input err_inj (1 bit): when high with we, the parity of the written lanes is inverted.
  - Extra output par_err (1 bit, reset 0): parity recomputed on the read word, aligned with rvalid. par_err=1 when any read lane mismatches; 0 whenever rvalid=0.
  - Collision mode 1 checks parity of the merged word.
- Without the macro: no parity storage, and err_inj/par_err ports are absent.

Test Plan:
- Reset, then release: busy=1 for exactly 8 cycles (DEPTH=8). Read every address -> rdata=0x0000 with rvalid=1, one cycle after re (RD_LATENCY=1).
- After init, write 0xA5A5 to addr 3 with wbe=2'b11, then wbe=2'b01 with 0x00FF -> read addr 3 returns 0xA5FF.
- Back-to-back re on addrs 0..7 after writing data=addr*0x1111 -> rvalid high for 8 consecutive cycles, rdata 0x0000..0x7777 in order. Repeat with RD_LATENCY=2: same data, shifted one cycle.
- Collision on addr 5 (old 0x1234, write 0xBEEF, wbe=2'b10) -> mode 0 returns 0x1234; mode 1 returns 0xBE34. Next read of addr 5 returns 0xBE34 in both modes.
- Pulse clr with a read in flight -> rvalid=0 that cycle, busy=1 for 8 cycles, writes during busy ignored. Addr 3 then reads 0x0000.
- DPRAM_PARITY_EN: write 0x00FF to addr 2 with err_inj=1 -> read addr 2 gives par_err=1 with rvalid. Rewrite with err_inj=0 -> par_err=0.

Source files
------------

// File: rtl/dual_port_ram_param.sv
// Parametrised simple dual-port RAM (one write port, one read port, one clock) with
// byte-lane writes, 1- or 2-cycle read latency, collision modes and a hardware init sweep.
// Optional per-lane even parity storage and checking is enabled by defining DPRAM_PARITY_EN.
module dual_port_ram_param #(
    parameter int                 DATA_W         = 16,
    parameter int                 ADDR_W         = 3,
    parameter int                 RD_LATENCY     = 1,
    parameter int                 COLLISION_MODE = 0,
    parameter logic [DATA_W-1:0]  INIT_VAL       = {DATA_W{1'b0}}
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  we,
    input  logic [DATA_W/8-1:0]   wbe,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic                  re,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [DATA_W-1:0]     rdata,
    output logic                  rvalid,
`ifdef DPRAM_PARITY_EN
    input  logic                  err_inj,
    output logic                  par_err,
`endif
    output logic                  busy
);

    localparam int                DEPTH     = 2**ADDR_W;
    localparam int                NLANE     = DATA_W/8;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH-1);

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    function automatic logic [DATA_W-1:0] merge_lanes(
        input logic [DATA_W-1:0] old_word,
        input logic [DATA_W-1:0] new_word,
        input logic [NLANE-1:0]  lane_en
    );
        logic [DATA_W-1:0] res;
        res = old_word;
        for (int i = 0; i < NLANE; i++) begin
            if (lane_en[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_word[8*i +: 8];
            end
        end
        return res;
    endfunction

`ifdef DPRAM_PARITY_EN
    function automatic logic [NLANE-1:0] lane_parity(input logic [DATA_W-1:0] word);
        logic [NLANE-1:0] par;
        par = {NLANE{1'b0}};
        for (int i = 0; i < NLANE; i++) begin
            par[i] = ^word[8*i +: 8];
        end
        return par;
    endfunction
`endif

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_cnt;
    logic [ADDR_W-1:0]   w_cnt_nxt;
    logic                r_busy;
    logic                w_ready;
    logic                w_wr_acc;
    logic                w_rd_acc;
    logic [DATA_W-1:0]   w_rd_word;
    logic                w_out_vld;
    logic [DATA_W-1:0]   w_out_data;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_rvalid;
    logic [DATA_W-1:0]   r_mem [DEPTH];

    // Sweep/ready sequencing: clr always (re)starts the sweep from address 0.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_INIT: begin
                if (clr) begin
                    w_state_nxt = ST_INIT;
                    w_cnt_nxt   = {ADDR_W{1'b0}};
                end else if (r_cnt == LAST_ADDR) begin
                    w_state_nxt = ST_READY;
                    w_cnt_nxt   = {ADDR_W{1'b0}};
                end else begin
                    w_state_nxt = ST_INIT;
                    w_cnt_nxt   = r_cnt + ADDR_W'(1'b1);
                end
            end
            ST_READY: begin
                if (clr) begin
                    w_state_nxt = ST_INIT;
                    w_cnt_nxt   = {ADDR_W{1'b0}};
                end else begin
                    w_state_nxt = ST_READY;
                    w_cnt_nxt   = r_cnt;
                end
            end
            default: begin
                w_state_nxt = ST_INIT;
                w_cnt_nxt   = {ADDR_W{1'b0}};
            end
        endcase
    end

    // State, sweep counter and busy flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_INIT;
            r_cnt   <= {ADDR_W{1'b0}};
            r_busy  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_busy  <= (w_state_nxt == ST_INIT);
        end
    end

    // A clr edge drops any write or read presented alongside it.
    always_comb begin
        w_ready  = (r_state == ST_READY);
        w_wr_acc = w_ready & ~clr & we;
        w_rd_acc = w_ready & ~clr & re;
    end

    // Read word, with the write-first bypass when configured.
    always_comb begin
        w_rd_word = r_mem[raddr];
        if ((COLLISION_MODE == 1) && w_wr_acc && (waddr == raddr)) begin
            w_rd_word = merge_lanes(r_mem[raddr], wdata, wbe);
        end else begin
            w_rd_word = r_mem[raddr];
        end
    end

    // Storage array: init sweep or byte-lane write; never reset directly.
    always_ff @(posedge clk) begin
        if (r_state == ST_INIT) begin
            r_mem[r_cnt] <= INIT_VAL;
        end else if (w_wr_acc) begin
            r_mem[waddr] <= merge_lanes(r_mem[waddr], wdata, wbe);
        end
    end

`ifdef DPRAM_PARITY_EN
    logic [NLANE-1:0] r_par [DEPTH];
    logic [NLANE-1:0] w_wpar;
    logic [NLANE-1:0] w_rd_par;
    logic [NLANE-1:0] w_out_par;
    logic             w_par_mis;
    logic             r_par_err;

    // Parity of the incoming write (optionally corrupted) and of the word being read.
    always_comb begin
        w_wpar   = lane_parity(wdata) ^ {NLANE{err_inj}};
        w_rd_par = r_par[raddr];
        if ((COLLISION_MODE == 1) && w_wr_acc && (waddr == raddr)) begin
            w_rd_par = (wbe & w_wpar) | (~wbe & r_par[raddr]);
        end else begin
            w_rd_par = r_par[raddr];
        end
    end

    // Parity store follows the data array lane by lane.
    always_ff @(posedge clk) begin
        if (r_state == ST_INIT) begin
            r_par[r_cnt] <= lane_parity(INIT_VAL);
        end else if (w_wr_acc) begin
            r_par[waddr] <= (wbe & w_wpar) | (~wbe & r_par[waddr]);
        end
    end
`endif

    generate
        if (RD_LATENCY == 2) begin : g_lat2
            logic              r_s1_vld;
            logic [DATA_W-1:0] r_s1_data;
            logic              w_flush;

            assign w_flush = ~w_ready | clr;

            // First read stage; the output stage discards it on a flush.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_s1_vld  <= 1'b0;
                    r_s1_data <= {DATA_W{1'b0}};
                end else begin
                    r_s1_vld <= w_rd_acc;
                    if (w_rd_acc) begin
                        r_s1_data <= w_rd_word;
                    end
                end
            end

            assign w_out_vld  = r_s1_vld & ~w_flush;
            assign w_out_data = r_s1_data;

`ifdef DPRAM_PARITY_EN
            logic [NLANE-1:0] r_s1_par;

            // Stored parity travels with the first-stage data.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_s1_par <= {NLANE{1'b0}};
                end else if (w_rd_acc) begin
                    r_s1_par <= w_rd_par;
                end
            end

            assign w_out_par = r_s1_par;
`endif
        end else begin : g_lat1
            assign w_out_vld  = w_rd_acc;
            assign w_out_data = w_rd_word;
`ifdef DPRAM_PARITY_EN
            assign w_out_par  = w_rd_par;
`endif
        end
    endgenerate

    // Output register: rdata only moves when a valid read lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata  <= {DATA_W{1'b0}};
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= w_out_vld;
            if (w_out_vld) begin
                r_rdata <= w_out_data;
            end
        end
    end

`ifdef DPRAM_PARITY_EN
    assign w_par_mis = |(lane_parity(w_out_data) ^ w_out_par);

    // Parity error flag, aligned with rvalid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_par_err <= 1'b0;
        end else begin
            r_par_err <= w_out_vld & w_par_mis;
        end
    end

    assign par_err = r_par_err;
`endif

    assign rdata  = r_rdata;
    assign rvalid = r_rvalid;
    assign busy   = r_busy;

endmodule

// File: tb/tb_dual_port_ram_param.sv
// Bench for dual_port_ram_param: two instances (latency 1 / read-old and latency 2 / write-first)
// share stimulus and are compared every cycle against a word-level reference model.
module tb_dual_port_ram_param;

    localparam int DEPTH = 8;

    logic        clk;
    logic        rst_n;
    logic        clr;
    logic        we;
    logic [1:0]  wbe;
    logic [2:0]  waddr;
    logic [15:0] wdata;
    logic        re;
    logic [2:0]  raddr;
    logic        err_inj;
    logic [15:0] rdata_a, rdata_b;
    logic        rvalid_a, rvalid_b;
    logic        busy_a, busy_b;
    logic        par_err_a, par_err_b;

    int n_checks;
    int n_errors;

    // Reference model state
    logic [15:0] m_mem [DEPTH];
    logic [1:0]  m_bad [DEPTH];
    int          m_left;
    logic        e_v  [2];
    logic [15:0] e_d  [2];
    logic        e_pe [2];
    logic        p_v;
    logic [15:0] p_d;
    logic        p_pe;

    dual_port_ram_param #(.DATA_W(16), .ADDR_W(3), .RD_LATENCY(1), .COLLISION_MODE(0)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .clr(clr), .we(we), .wbe(wbe), .waddr(waddr), .wdata(wdata),
        .re(re), .raddr(raddr), .rdata(rdata_a), .rvalid(rvalid_a),
`ifdef DPRAM_PARITY_EN
        .err_inj(err_inj), .par_err(par_err_a),
`endif
        .busy(busy_a)
    );

    dual_port_ram_param #(.DATA_W(16), .ADDR_W(3), .RD_LATENCY(2), .COLLISION_MODE(1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .clr(clr), .we(we), .wbe(wbe), .waddr(waddr), .wdata(wdata),
        .re(re), .raddr(raddr), .rdata(rdata_b), .rvalid(rvalid_b),
`ifdef DPRAM_PARITY_EN
        .err_inj(err_inj), .par_err(par_err_b),
`endif
        .busy(busy_b)
    );

`ifndef DPRAM_PARITY_EN
    assign par_err_a = 1'b0;
    assign par_err_b = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] merge(input logic [15:0] o, input logic [15:0] n, input logic [1:0] be);
        logic [15:0] r;
        r = o;
        for (int i = 0; i < 2; i++) if (be[i]) r[8*i +: 8] = n[8*i +: 8];
        return r;
    endfunction

    function automatic logic [1:0] merge_bad(input logic [1:0] o, input logic inj, input logic [1:0] be);
        logic [1:0] r;
        r = o;
        for (int i = 0; i < 2; i++) if (be[i]) r[i] = inj;
        return r;
    endfunction

    task automatic model_reset();
        m_left = DEPTH;
        for (int i = 0; i < 2; i++) begin
            e_v[i] = 1'b0; e_d[i] = 16'h0000; e_pe[i] = 1'b0;
        end
        p_v = 1'b0; p_d = 16'h0000; p_pe = 1'b0;
    endtask

    // Advance the model by one rising edge using the inputs currently driven.
    task automatic model_edge();
        logic [15:0] old_w, val_b;
        logic [1:0]  old_b;
        logic        pe_b, acc, flush, coll;
        acc   = (m_left == 0) && !clr;
        flush = clr || (m_left != 0);
        old_w = m_mem[raddr];
        old_b = m_bad[raddr];
        coll  = acc && we && re && (waddr == raddr);
        val_b = coll ? merge(old_w, wdata, wbe) : old_w;
        pe_b  = coll ? |merge_bad(old_b, err_inj, wbe) : |old_b;
        if (acc && re) begin
            e_v[0] = 1'b1; e_d[0] = old_w; e_pe[0] = |old_b;
        end else begin
            e_v[0] = 1'b0; e_pe[0] = 1'b0;
        end
        if (p_v && !flush) begin
            e_v[1] = 1'b1; e_d[1] = p_d; e_pe[1] = p_pe;
        end else begin
            e_v[1] = 1'b0; e_pe[1] = 1'b0;
        end
        p_v = acc && re; p_d = val_b; p_pe = pe_b;
        if (clr) begin
            m_left = DEPTH;
        end else if (m_left > 0) begin
            m_mem[DEPTH - m_left] = 16'h0000;
            m_bad[DEPTH - m_left] = 2'b00;
            m_left--;
        end else if (we) begin
            m_mem[waddr] = merge(m_mem[waddr], wdata, wbe);
            m_bad[waddr] = merge_bad(m_bad[waddr], err_inj, wbe);
        end
    endtask

    task automatic check_all();
        chk("busy_a", {31'd0, busy_a}, {31'd0, m_left != 0});
        chk("busy_b", {31'd0, busy_b}, {31'd0, m_left != 0});
        chk("rvalid_a", {31'd0, rvalid_a}, {31'd0, e_v[0]});
        chk("rvalid_b", {31'd0, rvalid_b}, {31'd0, e_v[1]});
        chk("rdata_a", {16'd0, rdata_a}, {16'd0, e_d[0]});
        chk("rdata_b", {16'd0, rdata_b}, {16'd0, e_d[1]});
`ifdef DPRAM_PARITY_EN
        chk("par_err_a", {31'd0, par_err_a}, {31'd0, e_pe[0]});
        chk("par_err_b", {31'd0, par_err_b}, {31'd0, e_pe[1]});
`endif
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle();
        clr = 1'b0; we = 1'b0; re = 1'b0; wbe = 2'b00; err_inj = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d, input logic [1:0] be);
        idle(); we = 1'b1; waddr = a; wdata = d; wbe = be;
        tick();
    endtask

    task automatic rd(input logic [2:0] a);
        idle(); re = 1'b1; raddr = a;
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0; waddr = 3'd0; raddr = 3'd0; wdata = 16'h0000;
        idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;

        // Init sweep: busy for exactly DEPTH cycles, then all words read INIT_VAL.
        repeat (DEPTH + 1) tick();
        for (int i = 0; i < DEPTH; i++) rd(3'(i));
        idle(); tick(); tick();

        // Byte-lane read-modify-write.
        wr(3'd3, 16'hA5A5, 2'b11);
        wr(3'd3, 16'h00FF, 2'b01);
        rd(3'd3);
        chk("rmw_a", {16'd0, rdata_a}, 32'h0000A5FF);
        idle(); tick();
        chk("rmw_b", {16'd0, rdata_b}, 32'h0000A5FF);

        // Back-to-back reads after a full pattern fill.
        for (int i = 0; i < DEPTH; i++) wr(3'(i), 16'(i * 16'h1111), 2'b11);
        for (int i = 0; i < DEPTH; i++) rd(3'(i));
        idle(); tick(); tick();

        // Same-address collision.
        wr(3'd5, 16'h1234, 2'b11);
        idle(); we = 1'b1; waddr = 3'd5; wdata = 16'hBEEF; wbe = 2'b10; re = 1'b1; raddr = 3'd5;
        tick();
        chk("coll_old_a", {16'd0, rdata_a}, 32'h00001234);
        idle(); tick();
        chk("coll_new_b", {16'd0, rdata_b}, 32'h0000BE34);
        rd(3'd5);
        chk("coll_after_a", {16'd0, rdata_a}, 32'h0000BE34);
        idle(); tick();
        chk("coll_after_b", {16'd0, rdata_b}, 32'h0000BE34);

        // clr with a read in flight; writes during the sweep are ignored.
        rd(3'd3);
        idle(); clr = 1'b1; re = 1'b1; raddr = 3'd3; we = 1'b1; waddr = 3'd3; wdata = 16'hFFFF; wbe = 2'b11;
        tick();
        chk("clr_rvalid_b", {31'd0, rvalid_b}, 32'd0);
        for (int i = 0; i < DEPTH; i++) begin
            idle(); we = 1'b1; waddr = 3'd3; wdata = 16'h5A5A; wbe = 2'b11; re = 1'b1; raddr = 3'(i);
            tick();
        end
        rd(3'd3);
        chk("clr_a3_a", {16'd0, rdata_a}, 32'h00000000);
        idle(); tick(); tick();

`ifdef DPRAM_PARITY_EN
        idle(); we = 1'b1; waddr = 3'd2; wdata = 16'h00FF; wbe = 2'b11; err_inj = 1'b1;
        tick();
        rd(3'd2);
        chk("perr_inj_a", {31'd0, par_err_a}, 32'd1);
        wr(3'd2, 16'h00FF, 2'b11);
        rd(3'd2);
        chk("perr_clean_a", {31'd0, par_err_a}, 32'd0);
        idle(); tick(); tick();
`endif

        // Randomised traffic, including occasional clr.
        for (int n = 0; n < 400; n++) begin
            clr     = ($urandom_range(0, 39) == 0);
            we      = 1'($urandom_range(0, 1));
            re      = 1'($urandom_range(0, 1));
            wbe     = 2'($urandom_range(0, 3));
            waddr   = 3'($urandom_range(0, 7));
            raddr   = ($urandom_range(0, 2) == 0) ? waddr : 3'($urandom_range(0, 7));
            wdata   = 16'($urandom);
            err_inj = ($urandom_range(0, 7) == 0);
            tick();
        end

        // Asynchronous reset in the middle of a read stream.
        rd(3'd1);
        idle(); re = 1'b1; raddr = 3'd2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle();
        repeat (DEPTH + 1) tick();
        for (int i = 0; i < DEPTH; i++) rd(3'(i));
        idle(); tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
